// File: rtl/muon_pkg.sv
// Shared types and constants for the muon counter sequencing blocks.
package muon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACQUIRE = 3'd2,
    SETTLE  = 3'd3,
    LATCH   = 3'd4
  } run_state_t;

  localparam int DEFAULT_TICKS_PER_UNIT = 100_000_000;
  localparam int COUNT_W                = 16;

endpackage

// File: rtl/gate_timer.sv
// Gate window timer: a tick prescaler feeding a unit down-counter.
// expire flags the final tick of the window so the owner can leave on that edge.
module gate_timer
  import muon_pkg::*;
#(
  parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
  parameter int GATE_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              run,
  input  logic [GATE_W-1:0] len,
  output logic              expire,
  output logic [GATE_W-1:0] units_left
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_UNIT - 1);

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap   = (presc == LAST_TICK);
  assign expire = run && wrap && (units_left == GATE_W'(1));

  // Anything other than load or run parks the timer at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      units_left <= '0;
    end else if (load) begin
      presc      <= '0;
      units_left <= len;
    end else if (run) begin
      if (wrap) begin
        presc      <= '0;
        units_left <= units_left - GATE_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end else begin
      presc      <= '0;
      units_left <= '0;
    end
  end

endmodule

// File: rtl/acq_run_controller.sv
// Timed acquisition run sequencer: clear, gate, settle, snapshot the counter bank.
//   state   | meaning
//   IDLE    | waiting for start
//   CLEAR   | one-cycle counter clear
//   ACQUIRE | gate open, timer counting
//   SETTLE  | gate closed, debounced pulses landing
//   LATCH   | snapshot counters, decide repeat or idle
module acq_run_controller
  import muon_pkg::*;
#(
  parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
  parameter int SETTLE_CYCLES  = 16,
  parameter int GATE_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [GATE_W-1:0]  gate_len,
  input  logic [COUNT_W-1:0] digits_A,
  input  logic [COUNT_W-1:0] digits_B,
  input  logic [COUNT_W-1:0] digits_C,
  output logic               cnt_enable,
  output logic               cnt_clear,
  output logic [COUNT_W-1:0] snap_A,
  output logic [COUNT_W-1:0] snap_B,
  output logic [COUNT_W-1:0] snap_C,
  output logic               snap_valid,
  output logic               snap_aborted,
  output logic               busy,
  output logic               cfg_err,
  output logic [COUNT_W-1:0] run_count,
  output logic [GATE_W-1:0]  units_left
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  run_state_t        state;
  logic [GATE_W-1:0] len_q;
  logic              cont_q;
  logic              stop_pending;
  logic              aborted;
  logic [SW-1:0]     settle_cnt;
  logic              timer_load;
  logic              timer_run;
  logic              timer_expire;

  assign timer_load = (state == CLEAR) && !stop;
  assign timer_run  = (state == ACQUIRE) && !stop;

  gate_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT),
    .GATE_W        (GATE_W)
  ) u_gate_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .run       (timer_run),
    .len       (len_q),
    .expire    (timer_expire),
    .units_left(units_left)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
      aborted      <= 1'b0;
      settle_cnt   <= '0;
      cnt_enable   <= 1'b0;
      cnt_clear    <= 1'b0;
      snap_A       <= '0;
      snap_B       <= '0;
      snap_C       <= '0;
      snap_valid   <= 1'b0;
      snap_aborted <= 1'b0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      run_count    <= '0;
    end else begin
      cnt_clear  <= 1'b0;
      snap_valid <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        // busy drops one cycle late so it still covers the snap_valid cycle.
        IDLE: begin
          busy <= 1'b0;
          if (start && !stop) begin
            if (gate_len == '0) begin
              cfg_err <= 1'b1;
            end else begin
              state     <= CLEAR;
              cnt_clear <= 1'b1;
              busy      <= 1'b1;
              len_q     <= gate_len;
              cont_q    <= continuous;
              aborted   <= 1'b0;
            end
          end
        end
        CLEAR: begin
          if (stop) begin
            state      <= SETTLE;
            aborted    <= 1'b1;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
          end else begin
            state      <= ACQUIRE;
            cnt_enable <= 1'b1;
          end
        end
        ACQUIRE: begin
          if (stop || timer_expire) begin
            state      <= SETTLE;
            cnt_enable <= 1'b0;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
            if (stop) aborted <= 1'b1;
          end
        end
        SETTLE: begin
          if (stop) stop_pending <= 1'b1;
          if (settle_cnt == '0) state <= LATCH;
          else settle_cnt <= settle_cnt - SW'(1);
        end
        LATCH: begin
          snap_A       <= digits_A;
          snap_B       <= digits_B;
          snap_C       <= digits_C;
          snap_aborted <= aborted;
          snap_valid   <= 1'b1;
          run_count    <= run_count + COUNT_W'(1);
          if (cont_q && !stop_pending && !stop && !aborted) begin
            state     <= CLEAR;
            cnt_clear <= 1'b1;
          end else begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            cont_q       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_run_controller.sv
// Self-checking bench for acq_run_controller: directed scenarios plus randomized runs
// checked cycle by cycle against a timeline model of each run.
module tb_acq_run_controller;

  localparam int TPU = 10;
  localparam int SET = 4;
  localparam int GW  = 16;

  logic          clk = 1'b0;
  logic          reset, start, stop, continuous;
  logic [GW-1:0] gate_len;
  logic [15:0]   digits_A, digits_B, digits_C;
  logic          cnt_enable, cnt_clear, snap_valid, snap_aborted, busy, cfg_err;
  logic [15:0]   snap_A, snap_B, snap_C, run_count;
  logic [GW-1:0] units_left;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_a = '0, m_b = '0, m_c = '0, m_cnt = '0;
  logic        m_ab = 1'b0;

  acq_run_controller #(
    .TICKS_PER_UNIT(TPU),
    .SETTLE_CYCLES (SET),
    .GATE_W        (GW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .gate_len    (gate_len),
    .digits_A    (digits_A),
    .digits_B    (digits_B),
    .digits_C    (digits_C),
    .cnt_enable  (cnt_enable),
    .cnt_clear   (cnt_clear),
    .snap_A      (snap_A),
    .snap_B      (snap_B),
    .snap_C      (snap_C),
    .snap_valid  (snap_valid),
    .snap_aborted(snap_aborted),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .run_count   (run_count),
    .units_left  (units_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_snaps();
    chk("snap_A", 32'(snap_A), 32'(m_a));
    chk("snap_B", 32'(snap_B), 32'(m_b));
    chk("snap_C", 32'(snap_C), 32'(m_c));
    chk("snap_aborted", 32'(snap_aborted), 32'(m_ab));
    chk("run_count", 32'(run_count), 32'(m_cnt));
  endtask

  // Relative cycle r of a run: 0 is CLEAR, gate open over [1, g), settle then latch.
  task automatic check_cycle(input int r, input int g, input int len, input bit sv);
    bit en;
    en = (r >= 1) && (r < g);
    chk("cnt_clear", 32'(cnt_clear), 32'(r == 0));
    chk("cnt_enable", 32'(cnt_enable), 32'(en));
    chk("units_left", 32'(units_left), en ? 32'(len - (r - 1) / TPU) : 32'd0);
    chk("snap_valid", 32'(snap_valid), 32'(sv));
    chk("busy", 32'(busy), 32'd1);
    chk("cfg_err", 32'(cfg_err), 32'd0);
    check_snaps();
  endtask

  // Stop requests apply to the last run only; -1 disables abort/late stop/spurious start.
  task automatic do_run(input int len, input bit cont, input int nrun, input int abort_at,
                        input int late_at, input int spur_at,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    int g;
    bit last, ab;
    start      = 1'b1;
    stop       = 1'b0;
    gate_len   = 16'(len);
    continuous = cont;
    @(negedge clk);
    start      = 1'b0;
    gate_len   = 16'($urandom_range(0, 9));
    continuous = 1'($urandom);
    for (int i = 0; i < nrun; i++) begin
      last = (i == nrun - 1);
      ab   = last && (abort_at >= 0);
      g    = ab ? abort_at + 1 : 1 + len * TPU;
      for (int r = 0; r <= g + SET; r++) begin
        check_cycle(r, g, len, (r == 0) && (i > 0));
        stop  = last && ((r == abort_at) || (r == late_at));
        start = (r == spur_at);
        if (start) gate_len = 16'($urandom_range(1, 9));
        digits_A = (r == g + SET) ? a + 16'(i) : 16'($urandom);
        digits_B = (r == g + SET) ? b + 16'(i) : 16'($urandom);
        digits_C = (r == g + SET) ? c + 16'(i) : 16'($urandom);
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
      end
      m_a   = a + 16'(i);
      m_b   = b + 16'(i);
      m_c   = c + 16'(i);
      m_ab  = ab;
      m_cnt = m_cnt + 16'd1;
      chk("snap_valid_pulse", 32'(snap_valid), 32'd1);
      check_snaps();
      if (last) begin
        chk("end_cnt_clear", 32'(cnt_clear), 32'd0);
        chk("end_cnt_enable", 32'(cnt_enable), 32'd0);
        chk("end_busy_hold", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_snap_valid", 32'(snap_valid), 32'd0);
    chk("idle_units_left", 32'(units_left), 32'd0);
    chk("idle_cnt_enable", 32'(cnt_enable), 32'd0);
    check_snaps();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt_enable"}, 32'(cnt_enable), 32'd0);
    chk({tag, "_cnt_clear"}, 32'(cnt_clear), 32'd0);
    chk({tag, "_snap_valid"}, 32'(snap_valid), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_units_left"}, 32'(units_left), 32'd0);
    check_snaps();
  endtask

  initial begin
    int len, nrun, mode, abort_at, late_at, spur, g;
    bit cont;
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; gate_len = '0;
    digits_A = 16'd0; digits_B = 16'd0; digits_C = 16'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Single run, abort, continuous with late stop, spurious start while busy.
    do_run(3, 1'b0, 1, -1, -1, -1, 16'd5, 16'd7, 16'd2);
    do_run(5, 1'b0, 1, 13, -1, -1, 16'h1111, 16'h2222, 16'h3333);
    do_run(1, 1'b1, 3, -1, 13, -1, 16'h0100, 16'h0200, 16'h0300);
    do_run(2, 1'b0, 1, -1, -1, 7, 16'hA0A0, 16'hB0B0, 16'hC0C0);
    do_run(2, 1'b1, 2, 0, -1, -1, 16'h4000, 16'h5000, 16'h6000);

    // Zero gate length is rejected with a cfg_err pulse.
    start = 1'b1; gate_len = '0; continuous = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_err_busy", 32'(busy), 32'd0);
    chk("cfg_err_clear", 32'(cnt_clear), 32'd0);
    @(negedge clk);
    chk("cfg_err_gone", 32'(cfg_err), 32'd0);
    chk("cfg_err_busy2", 32'(busy), 32'd0);

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; gate_len = 16'd3;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_all_zero("start_stop");
    @(negedge clk);
    check_all_zero("start_stop2");

    // Reset mid-ACQUIRE after a run that left snap_A = 9.
    do_run(1, 1'b0, 1, -1, -1, -1, 16'd9, 16'd4, 16'd3);
    chk("pre_reset_snap_A", 32'(snap_A), 32'd9);
    start = 1'b1; gate_len = 16'd5; continuous = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_run_enable", 32'(cnt_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_a = '0; m_b = '0; m_c = '0; m_ab = 1'b0; m_cnt = '0;
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("mid_reset2");

    // run_count wrap from 0xFFFF.
    force dut.run_count = 16'hFFFF;
    #1;
    release dut.run_count;
    m_cnt = 16'hFFFF;
    chk("preload_run_count", 32'(run_count), 32'h0000FFFF);
    do_run(1, 1'b0, 1, -1, -1, -1, 16'h0ABC, 16'h0DEF, 16'h0123);
    chk("wrapped_run_count", 32'(run_count), 32'd0);

    // Randomized runs with idle gaps carrying stray stop pulses.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) begin
        stop = 1'($urandom);
        @(negedge clk);
        stop = 1'b0;
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_cnt_clear", 32'(cnt_clear), 32'd0);
      end
      len  = $urandom_range(1, 4);
      cont = 1'($urandom_range(0, 1));
      nrun = cont ? $urandom_range(1, 3) : 1;
      mode = $urandom_range(0, 2);
      if (cont && mode == 0) mode = 2;
      abort_at = (mode == 1) ? $urandom_range(0, len * TPU) : -1;
      g        = (mode == 1) ? abort_at + 1 : 1 + len * TPU;
      late_at  = (mode == 2) ? $urandom_range(g, g + SET) : -1;
      spur     = ($urandom_range(0, 1) == 1) ? $urandom_range(0, g + SET) : -1;
      do_run(len, cont, nrun, abort_at, late_at, spur,
             16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
